// File: rtl/target_smoother_pkg.sv
// Shared state encoding, default tuning constants and a small distance helper
// for the target smoother.
package target_smoother_pkg;

   typedef enum logic [1:0] {
      LOST  = 2'd0,
      ACQ   = 2'd1,
      TRACK = 2'd2,
      COAST = 2'd3
   } smoother_state_t;

   localparam int unsigned DEF_FRAC        = 4;
   localparam int unsigned DEF_ALPHA_SHIFT = 2;
   localparam int unsigned DEF_X_MAX       = 320;
   localparam int unsigned DEF_Y_MAX       = 240;

   // Magnitude of a - b, evaluated in 10-bit signed arithmetic.
   function automatic logic [9:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
      logic signed [9:0] d;
      d = signed'({1'b0, a}) - signed'({1'b0, b});
      return (d < 0) ? 10'(-d) : 10'(d);
   endfunction

endpackage

// File: rtl/ema_filter.sv
// Single-channel exponential moving average with seed and update strobes.
// Output is the integer part of the fixed-point accumulator.
module ema_filter #(
   parameter int unsigned W           = 9,
   parameter int unsigned FRAC        = 4,
   parameter int unsigned ALPHA_SHIFT = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         seed_in,
   input  logic         update_in,
   input  logic [W-1:0] sample_in,
   output logic [W-1:0] value_out
);

   localparam int unsigned AW = W + FRAC + 1;

   logic signed [AW-1:0] r_acc;
   logic signed [AW-1:0] w_scaled;
   logic signed [AW-1:0] w_diff;

   // Both operands are non-negative and below 2^(W+FRAC), so the difference
   // and the updated accumulator always fit in AW signed bits.
   assign w_scaled = signed'({1'b0, sample_in, {FRAC{1'b0}}});
   assign w_diff   = w_scaled - r_acc;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_acc <= '0;
      end else if (seed_in) begin
         r_acc <= w_scaled;
      end else if (update_in) begin
         r_acc <= r_acc + (w_diff >>> ALPHA_SHIFT);
      end
   end

   assign value_out = r_acc[W+FRAC-1:FRAC];

endmodule

// File: rtl/target_smoother.sv
// Per-frame measurement gating, EMA smoothing and acquire/track/coast/lost
// sequencing between the colour tracker and the motion controller.
module target_smoother
   import target_smoother_pkg::*;
#(
   parameter int unsigned FRAC        = DEF_FRAC,
   parameter int unsigned ALPHA_SHIFT = DEF_ALPHA_SHIFT,
   parameter int unsigned MIN_RAD     = 16,
   parameter int unsigned MAX_JUMP    = 64,
   parameter int unsigned X_MAX       = DEF_X_MAX,
   parameter int unsigned Y_MAX       = DEF_Y_MAX,
   parameter int unsigned ACQ_FRAMES  = 3,
   parameter int unsigned LOST_FRAMES = 8
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        frame_done_in,
   input  logic [8:0]  x_in,
   input  logic [8:0]  y_in,
   input  logic [23:0] rad_in,
   output logic [8:0]  x_out,
   output logic [8:0]  y_out,
   output logic [23:0] rad_out,
   output logic        valid_out,
   output logic        coast_out,
   output logic        lost_out,
   output logic [1:0]  state_out
);

   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] ACQ_N   = CNT_W'(ACQ_FRAMES);
   localparam logic [CNT_W-1:0] LOST_N  = CNT_W'(LOST_FRAMES);
   localparam logic [23:0]      MIN_R   = 24'(MIN_RAD);
   localparam logic [9:0]       JUMP_M  = 10'(MAX_JUMP);
   localparam logic [9:0]       X_LIM   = 10'(X_MAX);
   localparam logic [9:0]       Y_LIM   = 10'(Y_MAX);

   smoother_state_t  r_state;
   logic             r_pend;
   logic             r_meas_ok;
   logic [8:0]       r_x, r_y;
   logic [23:0]      r_rad;
   logic [CNT_W-1:0] r_acq_cnt, r_miss_cnt;
   logic             r_valid, r_coast, r_lost;

   logic             w_accept, w_jump_ok, w_meas_ok;
   logic             w_seed, w_update;
   logic [CNT_W-1:0] w_acq_next, w_miss_next;

   // Jump gate compares against the outputs currently presented downstream.
   assign w_jump_ok = (r_state == LOST) ||
                      ((abs_diff9(x_in, x_out) <= JUMP_M) && (abs_diff9(y_in, y_out) <= JUMP_M));
   assign w_meas_ok = (rad_in >= MIN_R) && ({1'b0, x_in} < X_LIM) &&
                      ({1'b0, y_in} < Y_LIM) && w_jump_ok;
   assign w_accept  = frame_done_in && !r_pend;

   assign w_seed      = r_pend && r_meas_ok && (r_state == LOST);
   assign w_update    = r_pend && r_meas_ok && (r_state != LOST);
   assign w_acq_next  = (r_acq_cnt  == '1) ? r_acq_cnt  : r_acq_cnt  + 1'b1;
   assign w_miss_next = (r_miss_cnt == '1) ? r_miss_cnt : r_miss_cnt + 1'b1;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pend    <= 1'b0;
         r_meas_ok <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_rad     <= '0;
      end else begin
         r_pend <= w_accept;
         if (w_accept) begin
            r_meas_ok <= w_meas_ok;
            r_x       <= x_in;
            r_y       <= y_in;
            r_rad     <= rad_in;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= LOST;
         r_acq_cnt  <= '0;
         r_miss_cnt <= '0;
         r_valid    <= 1'b0;
         r_coast    <= 1'b0;
         r_lost     <= 1'b1;
      end else begin
         r_valid <= 1'b0;
         if (r_pend) begin
            unique case (r_state)
               LOST: if (r_meas_ok) begin
                  r_acq_cnt <= CNT_W'(1);
                  if (ACQ_N <= CNT_W'(1)) begin
                     r_state <= TRACK;
                     r_valid <= 1'b1;
                     r_lost  <= 1'b0;
                  end else begin
                     r_state <= ACQ;
                  end
               end
               ACQ: if (r_meas_ok) begin
                  r_acq_cnt <= w_acq_next;
                  if (w_acq_next >= ACQ_N) begin
                     r_state <= TRACK;
                     r_valid <= 1'b1;
                     r_lost  <= 1'b0;
                  end
               end else begin
                  r_acq_cnt <= '0;
                  r_state   <= LOST;
               end
               TRACK: begin
                  r_valid <= 1'b1;
                  if (!r_meas_ok) begin
                     r_state    <= COAST;
                     r_miss_cnt <= CNT_W'(1);
                     r_coast    <= 1'b1;
                  end
               end
               COAST: if (r_meas_ok) begin
                  r_state    <= TRACK;
                  r_miss_cnt <= '0;
                  r_coast    <= 1'b0;
                  r_valid    <= 1'b1;
               end else if (w_miss_next >= LOST_N) begin
                  r_state    <= LOST;
                  r_miss_cnt <= '0;
                  r_acq_cnt  <= '0;
                  r_coast    <= 1'b0;
                  r_lost     <= 1'b1;
               end else begin
                  r_miss_cnt <= w_miss_next;
                  r_valid    <= 1'b1;
               end
            endcase
         end
      end
   end

   ema_filter #(.W(9), .FRAC(FRAC), .ALPHA_SHIFT(ALPHA_SHIFT)) u_filt_x (
      .clk_in(clk_in), .rst_in(rst_in), .seed_in(w_seed), .update_in(w_update),
      .sample_in(r_x), .value_out(x_out)
   );
   ema_filter #(.W(9), .FRAC(FRAC), .ALPHA_SHIFT(ALPHA_SHIFT)) u_filt_y (
      .clk_in(clk_in), .rst_in(rst_in), .seed_in(w_seed), .update_in(w_update),
      .sample_in(r_y), .value_out(y_out)
   );
   ema_filter #(.W(24), .FRAC(FRAC), .ALPHA_SHIFT(ALPHA_SHIFT)) u_filt_rad (
      .clk_in(clk_in), .rst_in(rst_in), .seed_in(w_seed), .update_in(w_update),
      .sample_in(r_rad), .value_out(rad_out)
   );

   assign valid_out = r_valid;
   assign coast_out = r_coast;
   assign lost_out  = r_lost;
   assign state_out = r_state;

endmodule

// File: tb/tb_target_smoother.sv
// Randomised frame-level check of target_smoother against a behavioural
// reference model, plus the directed scenarios from the test plan.
module tb_target_smoother;

   logic        clk_in = 1'b0;
   logic        rst_in, frame_done_in;
   logic [8:0]  x_in, y_in;
   logic [23:0] rad_in;
   logic [8:0]  x_out, y_out;
   logic [23:0] rad_out;
   logic        valid_out, coast_out, lost_out;
   logic [1:0]  state_out;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: 0=LOST 1=ACQ 2=TRACK 3=COAST, accumulators x16
   int m_state;
   int m_acc[3];
   int m_acq, m_miss;
   int m_valid;

   always #5 clk_in = ~clk_in;

   target_smoother dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_done_in(frame_done_in),
      .x_in(x_in), .y_in(y_in), .rad_in(rad_in),
      .x_out(x_out), .y_out(y_out), .rad_out(rad_out),
      .valid_out(valid_out), .coast_out(coast_out), .lost_out(lost_out),
      .state_out(state_out)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int m_out(input int ch);
      return m_acc[ch] / 16;
   endfunction

   function automatic void model_reset();
      m_state = 0;
      m_acc   = '{0, 0, 0};
      m_acq   = 0;
      m_miss  = 0;
      m_valid = 0;
   endfunction

   function automatic void model_frame(input int x, input int y, input int r);
      int v[3];
      bit ok;
      v  = '{x, y, r};
      ok = (r >= 16) && (x < 320) && (y < 240) &&
           (m_state == 0 || (iabs(x - m_out(0)) <= 64 && iabs(y - m_out(1)) <= 64));
      m_valid = 0;
      if (ok) begin
         for (int i = 0; i < 3; i++) begin
            if (m_state == 0) m_acc[i] = v[i] * 16;
            else              m_acc[i] = m_acc[i] + ((v[i] * 16 - m_acc[i]) >>> 2);
         end
      end
      case (m_state)
         0: if (ok) begin m_acq = 1; m_state = 1; end
         1: if (ok) begin
               m_acq++;
               if (m_acq >= 3) begin m_state = 2; m_valid = 1; end
            end else begin
               m_acq = 0; m_state = 0;
            end
         2: begin
               m_valid = 1;
               if (!ok) begin m_state = 3; m_miss = 1; end
            end
         default: if (ok) begin
               m_state = 2; m_miss = 0; m_valid = 1;
            end else if (m_miss + 1 >= 8) begin
               m_state = 0; m_miss = 0; m_acq = 0;
            end else begin
               m_miss++; m_valid = 1;
            end
      endcase
   endfunction

   task automatic check_outputs(input string pfx);
      check_eq({pfx, ".valid"}, int'(valid_out), m_valid);
      check_eq({pfx, ".x"},     int'(x_out),     m_out(0));
      check_eq({pfx, ".y"},     int'(y_out),     m_out(1));
      check_eq({pfx, ".rad"},   int'(rad_out),   m_out(2));
      check_eq({pfx, ".state"}, int'(state_out), m_state);
      check_eq({pfx, ".lost"},  int'(lost_out),  (m_state <= 1) ? 1 : 0);
      check_eq({pfx, ".coast"}, int'(coast_out), (m_state == 3) ? 1 : 0);
   endtask

   // Called just after a rising edge; returns just after the edge ending T+2.
   task automatic send_frame(input int x, input int y, input int r, input bit extra);
      x_in = 9'(x); y_in = 9'(y); rad_in = 24'(r);
      frame_done_in = 1'b1;
      @(posedge clk_in); #1;
      if (extra) begin
         x_in = 9'(x ^ 'h0AA); y_in = 9'(y ^ 'h055); rad_in = 24'(r + 1000);
      end else begin
         frame_done_in = 1'b0;
      end
      check_eq("valid_t1", int'(valid_out), 0);
      @(posedge clk_in); #1;
      frame_done_in = 1'b0;
      model_frame(x, y, r);
      check_outputs("frame");
      @(posedge clk_in); #1;
      check_eq("valid_t3", int'(valid_out), 0);
   endtask

   task automatic mid_reset(input int x, input int y, input int r);
      x_in = 9'(x); y_in = 9'(y); rad_in = 24'(r);
      frame_done_in = 1'b1;
      @(posedge clk_in); #1;
      frame_done_in = 1'b0;
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in = 1'b0;
      model_reset();
      check_outputs("midrst");
      @(posedge clk_in); #1;
      check_eq("midrst.valid_t3", int'(valid_out), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_in = 1'b1; frame_done_in = 1'b0;
      x_in = '0; y_in = '0; rad_in = '0;
      model_reset();
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;
      check_outputs("reset");

      // acquire at (100,50,40)
      repeat (3) send_frame(100, 50, 40, 1'b0);
      check_eq("tp1.x", int'(x_out), 100);
      check_eq("tp1.state", int'(state_out), 2);

      // radius too small until lost
      for (int i = 0; i < 8; i++) send_frame(100, 50, 10, 1'b0);
      check_eq("tp3.lost", int'(lost_out), 1);

      // reacquire, then a jump coasts and a close frame resumes tracking
      repeat (3) send_frame(100, 50, 40, 1'b0);
      send_frame(200, 50, 40, 1'b0);
      check_eq("tp4.coast", int'(coast_out), 1);
      check_eq("tp4.xhold", int'(x_out), 100);
      send_frame(110, 50, 40, 1'b0);
      check_eq("tp4.x", int'(x_out), 102);

      // filter step response from 100
      mid_reset(0, 0, 0);
      repeat (3) send_frame(100, 50, 40, 1'b0);
      send_frame(120, 50, 40, 1'b0);
      check_eq("tp2.x1", int'(x_out), 105);
      send_frame(120, 50, 40, 1'b0);
      check_eq("tp2.x2", int'(x_out), 108);

      // off-frame during acquisition restarts the count
      mid_reset(0, 0, 0);
      repeat (2) send_frame(100, 50, 40, 1'b0);
      send_frame(330, 50, 40, 1'b0);
      check_eq("tp5.state", int'(state_out), 0);
      repeat (3) send_frame(100, 50, 40, 1'b0);
      check_eq("tp5.valid", int'(valid_out), 0);
      check_eq("tp5.state2", int'(state_out), 2);

      // reset one cycle after a frame strobe
      mid_reset(150, 60, 50);

      // frame strobe in the cycle after acceptance is ignored
      repeat (3) send_frame(200, 100, 300, 1'b1);

      // randomised frames
      for (int n = 0; n < 400; n++) begin
         int x, y, r, sel;
         sel = int'($urandom_range(0, 99));
         if (m_state == 0) begin
            x = int'($urandom_range(0, 340));
            y = int'($urandom_range(0, 260));
         end else begin
            x = m_out(0) + int'($urandom_range(0, 170)) - 85;
            y = m_out(1) + int'($urandom_range(0, 170)) - 85;
         end
         if (x < 0) x = 0;
         if (x > 511) x = 511;
         if (y < 0) y = 0;
         if (y > 511) y = 511;
         if (sel < 3) x = int'($urandom_range(320, 511));
         r = (sel >= 3 && sel < 18) ? int'($urandom_range(0, 16))
                                    : int'($urandom_range(16, 5_000_000));
         if (sel == 99) mid_reset(x, y, r);
         else           send_frame(x, y, r, ($urandom_range(0, 9) == 0));
         repeat ($urandom_range(0, 2)) @(posedge clk_in);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/target_smoother.md
Name: target_smoother

Overview:
- Per-frame conditioning stage between the colour tracker and the motion controller.
- Consumes raw centroid (x, y) and blob radius once per camera frame and rejects implausible measurements (too small, off-frame, jumps).
- Smooths accepted measurements with an exponential moving average.
- Runs an acquire/track/coast/lost state machine, then hands the controller filtered values, a one-cycle valid strobe and a target-lost flag.

Parameters:
- FRAC, 4, fractional bits in the filter accumulators
- ALPHA_SHIFT, 2, EMA gain = 2^-ALPHA_SHIFT
- MIN_RAD, 16, minimum rad_in for a valid measurement
- MAX_JUMP, 64, maximum |x_in-x_out| or |y_in-y_out| accepted in ACQ/TRACK/COAST
- X_MAX, 320, x_in must be < X_MAX
- Y_MAX, 240, y_in must be < Y_MAX
- ACQ_FRAMES, 3, consecutive valid frames to enter TRACK
- LOST_FRAMES, 8, consecutive invalid frames in COAST to declare LOST

Ports:
- clk_in  in  1  system clock (65 MHz pixel clock)
- rst_in  in  1  synchronous, active-high reset
- frame_done_in  in  1  one-cycle pulse; x_in/y_in/rad_in are stable on this cycle
- x_in  in  9  raw centroid x
- y_in  in  9  raw centroid y
- rad_in  in  24  raw blob radius
- x_out  out  9  filtered x
- y_out  out  9  filtered y
- rad_out  out  24  filtered radius
- valid_out  out  1  one-cycle strobe: outputs updated for this frame
- coast_out  out  1  1 while in COAST (outputs held)
- lost_out  out  1  1 in LOST/ACQ
- state_out  out  2  current state encoding, for the 7-segment debug display

Behaviour:
- Clocking: single clock clk_in. rst_in is synchronous, active-high.
- Reset values:
  - x_out=0, y_out=0, rad_out=0
  - valid_out=0, coast_out=0, lost_out=1
  - state=LOST; acq_cnt=0, miss_cnt=0; accumulators=0
- Pipeline:
  - frame_done_in at cycle T: inputs captured and classified; meas_ok registered at T+1.
  - At T+1 the state/filter update is computed.
  - Outputs, state and valid_out are registered at T+2. Latency is 2 cycles.
  - A frame_done_in arriving at T+1 is dropped.
- Validity: meas_ok = (rad_in >= MIN_RAD) & (x_in < X_MAX) & (y_in < Y_MAX) & jump_ok.
  - jump_ok is always 1 in LOST.
  - In all other states, jump_ok = |x_in-x_out| <= MAX_JUMP and |y_in-y_out| <= MAX_JUMP. Differences use 10-bit signed arithmetic.
- Filter, per channel:
  - Accumulator acc is signed, width W+FRAC+1.
  - seed: acc <= in<<FRAC.
  - update: acc <= acc + (((in<<FRAC) - acc) >>> ALPHA_SHIFT), with an arithmetic shift.
  - Output = acc[W+FRAC-1:FRAC], truncated. It never goes negative because inputs are unsigned.
- States (state_out encoding):
  - LOST = 0, ACQ = 1, TRACK = 2, COAST = 3.
  - Encoding lives in the package.
- LOST:
  - meas_ok: seed filter, acc_cnt=1, go to ACQ. If ACQ_FRAMES==1, go directly to TRACK with valid_out.
  - Otherwise stay in LOST; no valid_out.
- ACQ:
  - meas_ok: update filter and increment acq_cnt. When acq_cnt reaches ACQ_FRAMES, go to TRACK, pulse valid_out and set lost_out=0.
  - !meas_ok: acq_cnt=0, go to LOST; filter contents are retained but unused.
- TRACK:
  - meas_ok: update filter, pulse valid_out.
  - !meas_ok: go to COAST with miss_cnt=1, hold outputs, pulse valid_out, coast_out=1.
- COAST:
  - meas_ok: update filter, go to TRACK, miss_cnt=0, coast_out=0, pulse valid_out.
  - !meas_ok: increment miss_cnt and pulse valid_out with held values.
  - When miss_cnt reaches LOST_FRAMES, go to LOST instead: lost_out=1, coast_out=0, no valid_out on that frame.
- valid_out is never asserted in LOST or ACQ, and is never high for two consecutive cycles.
- Reset mid-pipeline: any in-flight frame is discarded and all registers take their reset values on the next edge.
- Counters saturate and never wrap.

Decomposition:
- Package target_smoother_pkg:
  - state enum smoother_state_t {LOST, ACQ, TRACK, COAST} (2-bit)
  - default constants for FRAC, ALPHA_SHIFT, X_MAX, Y_MAX
- Sub-module ema_filter, parameterised by W, FRAC, ALPHA_SHIFT:
  - Inputs: seed and update strobes, the sample and clk_in/rst_in.
  - Output: the filtered value.
  - Instantiated three times (x, y, rad).

Test Plan:
- Reset then 3 frames of x=100, y=50, rad=40 -> no valid_out on frames 1–2; frame 3: valid_out at T+2, lost_out=0, state_out=2, x_out=100, y_out=50.
- In TRACK at x=100 (acc=1600), frame x=120 -> x_out=105; another x=120 -> x_out=108.
- In TRACK, rad_in=10 for 8 frames -> frames 1–7: coast_out=1, valid_out pulses, x_out held at 100; frame 8: state_out=0, lost_out=1, no valid_out.
- In TRACK with x_out=100, frame x=200 (jump 100>64) -> COAST, outputs held; next frame x=110 -> TRACK, x_out=102.
- During ACQ (acq_cnt=2), frame with x_in=330 -> state_out=0, next 3 valid frames required again before valid_out.
- Assert rst_in one cycle after frame_done_in -> no valid_out, all outputs at reset values, lost_out=1.
